// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: serialises M0/M1 accesses onto the shared system bus, round-robin by default.
// Define ARB_FIXED_PRIO_EN for fixed priority (M0 always wins a tie).
module bus_master_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    output logic              s_re,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              sel;

`ifdef ARB_FIXED_PRIO_EN
    assign sel = ~m0_req;
`else
    logic rr_q, rr_d;
    assign sel = (m0_req && m1_req) ? rr_q : m1_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: if (m0_req || m1_req) begin
                owner_d = sel;
                we_d    = sel ? m1_we : m0_we;
                addr_d  = sel ? m1_addr : m0_addr;
                wdata_d = sel ? m1_wdata : m0_wdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = we_q ? DONE : WAIT;
            end
            WAIT: if (cnt_q == 3'd0) begin
                rdata_d = s_rdata;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            DONE: begin
`ifndef ARB_FIXED_PRIO_EN
                rr_d    = ~owner_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
`ifndef ARB_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Strobes decode straight from state so an async reset kills them in the same cycle.
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_we    = (state_q == ISSUE) && we_q;
    assign s_re    = ((state_q == ISSUE) && !we_q) || (state_q == WAIT);
    assign m0_gnt  = (state_q == ISSUE) && !owner_q;
    assign m1_gnt  = (state_q == ISSUE) && owner_q;
    assign m0_done = (state_q == DONE) && !owner_q;
    assign m1_done = (state_q == DONE) && owner_q;
    assign m_rdata = rdata_q;
    assign owner   = owner_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: directed and random checks of bus_master_arbiter (default round-robin build).
module tb_bus_master_arbiter;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [63:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_done, m1_gnt, m1_done, s_we, s_re, owner, busy;
    logic [63:0] m_rdata, s_addr, s_wdata;
    logic [63:0] s_rdata = '0, p1 = '0;
    logic [63:0] mem [0:255];
    logic        swe_prev = 1'b0;
    int          n_chk = 0, n_pass = 0, viol = 0;

    always #5 clk = ~clk;

    bus_master_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done),
        .m_rdata(m_rdata), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_we(s_we), .s_re(s_re), .s_rdata(s_rdata), .owner(owner), .busy(busy)
    );

    // Slave: write on s_we, read data valid two cycles after the address is presented.
    always @(posedge clk) begin
        if (s_we) mem[s_addr[9:2]] <= s_wdata;
        p1      <= mem[s_addr[9:2]];
        s_rdata <= p1;
    end

    always @(negedge clk) begin
        if (int'(m0_gnt) + int'(m1_gnt) + int'(m0_done) + int'(m1_done) > 1 || (s_we && swe_prev))
            viol <= viol + 1;
        swe_prev <= s_we;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit on, input bit we, input logic [63:0] a, input logic [63:0] d);
        if (m) begin m1_req = on; m1_we = we; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = on; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic txn(input bit m, input bit we, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd);
        bit seen = 0;
        rd = '0;
        drive(m, 1, we, a, d);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (m ? m1_done : m0_done) begin seen = 1; rd = m_rdata; end
        end
        drive(m, 0, we, a, d);
        chk("txn done", 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        logic [63:0] rd, d;
        logic [63:0] sb [0:7];
        logic [3:0]  order;
        int          cnt, nd;
        tick(); tick();
        chk("rst strobes", {m0_gnt, m0_done, m1_gnt, m1_done, s_we, s_re, owner, busy}, 0);
        chk("rst s_addr", s_addr, 0);
        chk("rst m_rdata", m_rdata, 0);
        reset_n = 1'b1;
        tick();
        // M0 write
        drive(0, 1, 1, 64'h1000, 64'hDEAD);
        tick();
        chk("w gnt c1", m0_gnt, 1);
        chk("w s_we c1", s_we, 1);
        chk("w s_addr c1", s_addr, 64'h1000);
        chk("w s_wdata c1", s_wdata, 64'hDEAD);
        tick();
        chk("w done c2", m0_done, 1);
        chk("w s_we c2", s_we, 0);
        drive(0, 0, 1, 64'h1000, 64'hDEAD);
        tick();
        chk("w idle c3", busy, 0);
        chk("addr hold", s_addr, 64'h1000);
        txn(1, 1, 64'h1004, 64'h12345678, rd);
        // M1 read
        drive(1, 1, 0, 64'h1004, 0);
        tick();
        chk("r gnt c1", m1_gnt, 1);
        chk("r s_re c1", s_re, 1);
        chk("r s_addr c1", s_addr, 64'h1004);
        tick();
        chk("r s_re c2", s_re, 1);
        tick();
        chk("r s_re c3", s_re, 1);
        chk("r no done c3", m1_done, 0);
        tick();
        chk("r done c4", m1_done, 1);
        chk("r rdata c4", m_rdata, 64'h12345678);
        chk("r s_re c4", s_re, 0);
        chk("r owner", owner, 1);
        drive(1, 0, 0, 64'h1004, 0);
        tick();
        // Round-robin with both requesting
        drive(0, 1, 1, 64'h1008, 64'h1);
        drive(1, 1, 1, 64'h100c, 64'h2);
        order = '0; cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            tick();
            if (m0_gnt || m1_gnt) begin
                order[cnt] = m1_gnt;
                cnt++;
                if (cnt == 4) begin drive(0, 0, 1, 0, 0); drive(1, 0, 1, 0, 0); end
            end
        end
        chk("rr count", 64'(cnt), 4);
        chk("rr order", 64'(order), 64'b1010);
        tick(); tick(); tick();
        // Request dropped right after grant
        drive(0, 1, 0, 64'h1000, 0);
        tick();
        chk("drop gnt", m0_gnt, 1);
        drive(0, 0, 0, 0, 0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin tick(); nd += int'(m0_done); end
        chk("drop done cnt", 64'(nd), 1);
        chk("drop rdata", m_rdata, 64'hDEAD);
        // Async reset during read WAIT
        drive(0, 1, 0, 64'h1004, 0);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("abort s_re", s_re, 0);
        chk("abort busy", busy, 0);
        chk("abort rdata", m_rdata, 0);
        drive(0, 0, 0, 0, 0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin tick(); nd += int'(m0_done | m1_done); end
        chk("abort no done", 64'(nd), 0);
        reset_n = 1'b1;
        tick();
        txn(0, 0, 64'h1004, 0, rd);
        chk("post rst read", rd, 64'h12345678);
        // Random traffic against a scoreboard
        for (int k = 0; k < 8; k++) begin
            d = {$urandom, $urandom};
            sb[k] = d;
            txn(1'($urandom_range(1)), 1, 64'h2000 + 64'(4 * k), d, rd);
        end
        for (int i = 0; i < 24; i++) begin
            int k = $urandom_range(7);
            bit m = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                d = {$urandom, $urandom};
                sb[k] = d;
                txn(m, 1, 64'h2000 + 64'(4 * k), d, rd);
            end else begin
                txn(m, 0, 64'h2000 + 64'(4 * k), 0, rd);
                chk("rnd read", rd, sb[k]);
            end
        end
        chk("exclusive pulses", 64'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
